// File: rtl/gf_pkg.sv
// Shared types, widths and helpers for the GF(2^SIZE) polynomial arithmetic blocks.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int flat_w(input int n, input int size);
        return (n + 1) * size;
    endfunction

    function automatic int large_w(input int n, input int size);
        return (2 * n + 1) * size;
    endfunction

    function automatic int cnt_w(input int n);
        return (n + 1 <= 2) ? 1 : $clog2(n + 1);
    endfunction

    // Width of the i+j accumulator index, which spans 0..2n.
    function automatic int acc_idx_w(input int n);
        return (2 * n + 1 <= 2) ? 1 : $clog2(2 * n + 1);
    endfunction

    function automatic int coef_lo(input int k, input int size);
        return k * size;
    endfunction

    // Reduction polynomial per field width; the x^SIZE term is implicit.
    function automatic logic [31:0] prim_poly(input int size);
        case (size)
            2:       return 32'h7;
            3:       return 32'hb;
            4:       return 32'h13;
            5:       return 32'h25;
            6:       return 32'h43;
            7:       return 32'h89;
            default: return 32'h11d;
        endcase
    endfunction

    localparam int DEF_M     = 255;
    localparam int DEF_SIZE  = 8;
    localparam int DEF_N     = 2;
    localparam int DEF_FLAT  = flat_w(DEF_N, DEF_SIZE);
    localparam int DEF_LARGE = large_w(DEF_N, DEF_SIZE);
    localparam int DEF_CW    = cnt_w(DEF_N);

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^SIZE) multiplier: shift-and-add with per-step modular reduction.
module gf_mul
    import gf_pkg::*;
#(
    parameter int m    = 255,
    parameter int SIZE = $clog2(m)
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] z
);

    localparam logic [31:0]     POLY_FULL = prim_poly(SIZE);
    localparam logic [SIZE-1:0] POLY      = POLY_FULL[SIZE-1:0];

    logic [SIZE-1:0] shifted;

    always_comb begin
        z       = '0;
        shifted = a;
        for (int k = 0; k < SIZE; k++) begin
            if (b[k]) begin
                z = z ^ shifted;
            end
            shifted = {shifted[SIZE-2:0], 1'b0} ^ (shifted[SIZE-1] ? POLY : '0);
        end
    end

endmodule

// File: rtl/gf_poly_mul_seq.sv
// Sequential polynomial multiplier over GF(2^SIZE): one gf_mul shared across all
// (n+1)^2 coefficient pairs, XOR-accumulated into a 2n+1 coefficient result.
module gf_poly_mul_seq
    import gf_pkg::*;
#(
    parameter int m                = 255,
    parameter int SIZE             = $clog2(m),
    parameter int n                = 2,
    parameter int flat_size        = (n + 1) * SIZE,
    parameter int large_array_size = (2 * n + 1) * SIZE,
    parameter int CW               = cnt_w(n)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [flat_size-1:0]        flat_p,
    input  logic [flat_size-1:0]        flat_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [large_array_size-1:0] flat_z,
    output logic                        busy
);

    localparam int AW    = acc_idx_w(n);
    localparam int NACC  = 2 * n + 1;

    state_t                        state_q, state_d;
    logic [flat_size-1:0]          p_q, q_q;
    logic [large_array_size-1:0]   acc_q, acc_d;
    logic [CW-1:0]                 i_q, j_q;
    logic [SIZE-1:0]               p_sel, q_sel, prod;
    logic [AW-1:0]                 idx;
    logic [NACC-1:0]               acc_we;
    logic                          accept, run, last;

    assign accept = (state_q == IDLE) && in_valid;
    assign run    = (state_q == RUN);
    assign last   = run && (i_q == CW'(n)) && (j_q == CW'(n));
    assign idx    = AW'(i_q) + AW'(j_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
            q_q <= '0;
            i_q <= '0;
            j_q <= '0;
        end else if (accept) begin
            p_q <= flat_p;
            q_q <= flat_q;
            i_q <= '0;
            j_q <= '0;
        end else if (run) begin
            if (j_q == CW'(n)) begin
                j_q <= '0;
                i_q <= last ? '0 : i_q + CW'(1);
            end else begin
                j_q <= j_q + CW'(1);
            end
        end
    end

    always_comb begin
        p_sel = '0;
        q_sel = '0;
        for (int k = 0; k <= n; k++) begin
            if (i_q == CW'(k)) p_sel = p_q[k*SIZE +: SIZE];
            if (j_q == CW'(k)) q_sel = q_q[k*SIZE +: SIZE];
        end
    end

    gf_mul #(
        .m    (m),
        .SIZE (SIZE)
    ) u_gf_mul (
        .a (p_sel),
        .b (q_sel),
        .z (prod)
    );

    generate
        for (genvar gi = 0; gi < NACC; gi++) begin : g_acc_dec
            assign acc_we[gi] = run && (idx == AW'(gi));
        end
    endgenerate

    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < NACC; k++) begin
            if (acc_we[k]) begin
                acc_d[coef_lo(k, SIZE) +: SIZE] = acc_q[coef_lo(k, SIZE) +: SIZE] ^ prod;
            end
        end
    end

    // The accumulator doubles as the output register; cleared only when a new job starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign flat_z = acc_q;

endmodule

// File: tb/tb_gf_poly_mul_seq.sv
// Self-checking bench for gf_poly_mul_seq at n=2, SIZE=8 against a log/antilog GF model.
module tb_gf_poly_mul_seq;

    localparam int SIZE  = 8;
    localparam int N     = 2;
    localparam int FW    = (N + 1) * SIZE;
    localparam int LW    = (2 * N + 1) * SIZE;
    localparam int LAT   = (N + 1) * (N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] flat_p = '0;
    logic [FW-1:0] flat_q = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LW-1:0] flat_z;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    int exp_t [0:254];
    int log_t [0:255];

    typedef struct {
        string         name;
        logic [FW-1:0] p;
        logic [FW-1:0] q;
        logic [LW-1:0] z;
    } vec_t;

    gf_poly_mul_seq #(
        .m (255), .SIZE (SIZE), .n (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flat_p    (flat_p),
        .flat_q    (flat_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flat_z    (flat_z),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_tables();
        int x = 1;
        for (int k = 0; k < 255; k++) begin
            exp_t[k] = x;
            log_t[x] = k;
            x = x << 1;
            if (x & 'h100) x = x ^ 'h11d;
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function automatic logic [LW-1:0] poly_ref(input logic [FW-1:0] p, input logic [FW-1:0] q);
        int zc [0:2*N];
        logic [LW-1:0] r = '0;
        for (int k = 0; k <= 2 * N; k++) zc[k] = 0;
        for (int a = 0; a <= N; a++)
            for (int b = 0; b <= N; b++)
                zc[a+b] = zc[a+b] ^ gmul(int'(p[a*SIZE +: SIZE]), int'(q[b*SIZE +: SIZE]));
        for (int k = 0; k <= 2 * N; k++) r[k*SIZE +: SIZE] = zc[k][SIZE-1:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete job: optional idle gap, accept, optional operand scrambling during RUN,
    // optional early out_ready, and bp cycles of back-pressure in DONE.
    task automatic do_job(input logic [FW-1:0] p, input logic [FW-1:0] q, input int gap,
                          input int bp, input bit early, input bit scramble,
                          output logic [LW-1:0] z, output int lat, output bit stable);
        bit rdy;
        bit ok;
        in_valid = 1'b0;
        repeat (gap) tick();
        flat_p = p;
        flat_q = q;
        in_valid = 1'b1;
        out_ready = early;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 0, 1);
        if (!scramble) in_valid = 1'b0;
        lat = 0;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (scramble) begin
                flat_p = FW'($urandom);
                flat_q = FW'($urandom);
            end
            tick();
            lat++;
            if (out_valid) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!ok) check("done_timeout", 0, 1);
        z = flat_z;
        stable = 1'b1;
        if (!early) begin
            repeat (bp) begin
                tick();
                if (flat_z !== z || out_valid !== 1'b1) stable = 1'b0;
            end
            out_ready = 1'b1;
        end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs [6];
        logic [LW-1:0] z;
        int lat;
        bit stable;
        bit seen;
        int hs0;

        build_tables();
        vecs[0] = '{"p_unit",  24'h000001, 24'h030201, 40'h0000030201};
        vecs[1] = '{"p_x",     24'h000100, 24'h030201, 40'h0003020100};
        vecs[2] = '{"p_x2",    24'h010000, 24'h030201, 40'h0302010000};
        vecs[3] = '{"p_zero",  24'h000000, 24'hffffff, 40'h0000000000};
        vecs[4] = '{"reduce",  24'h000002, 24'h000080, 40'h000000001d};
        vecs[5] = '{"xor_acc", 24'h010101, 24'h010101, 40'h0100010001};

        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_flat_z", flat_z, 0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 1);
        check("idle_flat_z", flat_z, 0);

        for (int v = 0; v < 6; v++) begin
            do_job(vecs[v].p, vecs[v].q, 0, 1, 1'b0, 1'b0, z, lat, stable);
            check({vecs[v].name, "_z"}, z, vecs[v].z);
            check({vecs[v].name, "_lat"}, lat, LAT);
            $display("vec %s p=%h q=%h z=%h lat=%0d", vecs[v].name, vecs[v].p, vecs[v].q, z, lat);
        end
        check("last_result_kept", flat_z, vecs[5].z);
        check("idle_after_job", in_ready, 1);

        // Reset in the middle of RUN aborts the job silently.
        flat_p = 24'h123456;
        flat_q = 24'h654321;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("run_busy", busy, 1);
        check("run_in_ready", in_ready, 0);
        repeat (4) tick();
        rst_n = 1'b0;
        seen = 1'b0;
        hs0 = hs_cnt;
        repeat (2) begin tick(); if (out_valid) seen = 1'b1; end
        rst_n = 1'b1;
        for (int t = 0; t < 15; t++) begin tick(); if (out_valid) seen = 1'b1; end
        check("abort_no_valid", seen, 0);
        check("abort_flat_z", flat_z, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        do_job(24'h123456, 24'h654321, 0, 0, 1'b0, 1'b0, z, lat, stable);
        check("post_abort_z", z, poly_ref(24'h123456, 24'h654321));
        $display("post-abort job z=%h lat=%0d", z, lat);

        // out_ready with in_valid in DONE only retires; the new job is taken a cycle later.
        flat_p = 24'h0a0b0c;
        flat_q = 24'h112233;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int t = 0; t < 20 && !out_valid; t++) tick();
        check("done_reached", out_valid, 1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        flat_p = 24'h000001;
        flat_q = 24'h0000ff;
        tick();
        out_ready = 1'b0;
        check("done_to_idle_ready", in_ready, 1);
        check("done_to_idle_busy", busy, 0);
        check("done_result_kept", flat_z, poly_ref(24'h0a0b0c, 24'h112233));
        tick();
        in_valid = 1'b0;
        check("next_accept_busy", busy, 1);
        for (int t = 0; t < 20 && !out_valid; t++) tick();
        check("next_job_z", flat_z, 40'h00000000ff);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Held in_valid with scrambled operands during RUN.
        do_job(24'h020304, 24'h050607, 0, 2, 1'b0, 1'b1, z, lat, stable);
        check("scramble_z", z, poly_ref(24'h020304, 24'h050607));
        check("scramble_lat", lat, LAT);
        $display("scramble job z=%h lat=%0d", z, lat);

        // Randomized jobs with gaps, back-pressure and early out_ready.
        hs0 = hs_cnt;
        for (int jn = 0; jn < 1000; jn++) begin
            logic [FW-1:0] rp, rq;
            logic [LW-1:0] zr;
            bit early;
            rp = FW'($urandom);
            rq = FW'($urandom);
            early = ($urandom_range(0, 3) == 0);
            do_job(rp, rq, $urandom_range(0, 3), $urandom_range(0, 3), early,
                   ($urandom_range(0, 3) == 0), z, lat, stable);
            zr = poly_ref(rp, rq);
            check("rand_z", z, zr);
            check("rand_lat", lat, LAT);
            check("rand_stable", stable, 1);
            $display("job %0d p=%h q=%h z=%h exp=%h", jn, rp, rq, z, zr);
        end
        tick();
        check("rand_handshakes", hs_cnt - hs0, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
